// File: rtl/gbt_link_pkg.sv
// Shared definitions for the GBT slow-control link (RX decoder and TX packer).
package gbt_link_pkg;

    // Default payload of the packet trailer frame
    localparam logic [11:0] FRAME_END_DEFAULT = 12'hABC;

    // Default payload[11:8] tag that marks a start frame
    localparam logic [3:0]  START_TAG_DEFAULT = 4'hC;

    // Frame field positions inside a 16-bit GBT e-link word
    localparam int TTC_MSB     = 15;
    localparam int TTC_LSB     = 12;
    localparam int PAYLOAD_MSB = 11;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;

    // Packet framing states, one frame per state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        D1    = 2'd1,
        D2    = 2'd2,
        TRAIL = 2'd3
    } link_state_e;

    // True when a payload carries the start tag in its top nibble
    function automatic logic is_start_frame(input logic [PAYLOAD_W-1:0] payload,
                                            input logic [3:0]           tag);
        return payload[11:8] == tag;
    endfunction

endpackage

// File: rtl/reset_sync_n.sv
// Active-low reset synchroniser: asserts asynchronously, releases after two clock edges.
module reset_sync_n (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic rst_n_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // Shift a constant one through the chain so release lines up with the clock
    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    // Chain clears immediately whenever the raw reset is asserted
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_o = sync_q[1];

endmodule

// File: rtl/gbt_rx_link.sv
// Receive-side GBT link decoder: reassembles 4-frame slow-control packets into 32-bit requests.
module gbt_rx_link
    import gbt_link_pkg::*;
#(
    parameter logic [11:0] FRAME_END = FRAME_END_DEFAULT,
    parameter logic [3:0]  START_TAG = START_TAG_DEFAULT
) (
    input  logic        ttc_clk_40_i,
    input  logic        reset_n_i,
    input  logic [15:0] gbt_rx_data_i,
    output logic        req_en_o,
    output logic [31:0] req_data_o
);

    logic                 rst_n;
    logic [PAYLOAD_W-1:0] payload;
    logic                 unused_ttc;

    link_state_e          state_q, state_d;
    logic [31:0]          shadow_q, shadow_d;
    logic                 req_en_q, req_en_d;
    logic [31:0]          req_data_q, req_data_d;

    reset_sync_n u_reset_sync (
        .clk_i   (ttc_clk_40_i),
        .rst_n_i (reset_n_i),
        .rst_n_o (rst_n)
    );

    assign payload    = gbt_rx_data_i[PAYLOAD_MSB:PAYLOAD_LSB];
    assign unused_ttc = ^gbt_rx_data_i[TTC_MSB:TTC_LSB];

    // Framing FSM; a failed trailer is re-examined as a possible start frame
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        req_en_d   = 1'b0;
        req_data_d = req_data_q;
        unique case (state_q)
            IDLE: begin
                if (is_start_frame(payload, START_TAG)) begin
                    shadow_d[31:24] = payload[7:0];
                    state_d         = D1;
                end
            end
            D1: begin
                shadow_d[23:12] = payload;
                state_d         = D2;
            end
            D2: begin
                shadow_d[11:0] = payload;
                state_d        = TRAIL;
            end
            TRAIL: begin
                if (payload == FRAME_END) begin
                    req_en_d   = 1'b1;
                    req_data_d = shadow_q;
                    state_d    = IDLE;
                end else if (is_start_frame(payload, START_TAG)) begin
                    shadow_d[31:24] = payload[7:0];
                    state_d         = D1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow and output registers; reset discards any partial packet
    always_ff @(posedge ttc_clk_40_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_q   <= 32'h0;
            req_en_q   <= 1'b0;
            req_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            req_en_q   <= req_en_d;
            req_data_q <= req_data_d;
        end
    end

    assign req_en_o   = req_en_q;
    assign req_data_o = req_data_q;

endmodule

// File: tb/tb_gbt_rx_link.sv
// Directed testbench for gbt_rx_link: vector table plus reset corner sequences.
module tb_gbt_rx_link;

    typedef struct {
        logic [15:0] frame;
        logic        exp_en;
        logic [31:0] exp_data;
        string       name;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] gbt_data;
    logic        req_en;
    logic [31:0] req_data;

    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];

    gbt_rx_link dut (
        .ttc_clk_40_i  (clk),
        .reset_n_i     (reset_n),
        .gbt_rx_data_i (gbt_data),
        .req_en_o      (req_en),
        .req_data_o    (req_data)
    );

    // 40 MHz clock
    initial begin
        clk = 1'b0;
        forever #12 clk = ~clk;
    end

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Queue one vector: frame presented and outputs expected after the sampling edge
    task automatic addVec(input logic [15:0] frame, input logic exp_en,
                          input logic [31:0] exp_data, input string name);
        vec_t v;
        v.frame    = frame;
        v.exp_en   = exp_en;
        v.exp_data = exp_data;
        v.name     = name;
        vecs.push_back(v);
    endtask

    // Drive a frame on the falling edge and return just after the sampling rising edge
    task automatic applyStimulus(input logic [15:0] frame);
        @(negedge clk);
        gbt_data = frame;
        @(posedge clk);
        #1;
    endtask

    // Compare both outputs against expected values
    task automatic checkOutput(input string name, input logic exp_en, input logic [31:0] exp_data);
        testsRun++;
        if (req_en !== exp_en || req_data !== exp_data) begin
            testsFailed++;
            $display("[TB] FAIL %s: got en=%b data=%h, expected en=%b data=%h",
                     name, req_en, req_data, exp_en, exp_data);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        gbt_data    = 16'h0000;
        reset_n     = 1'b0;

        // Outputs must be cleared while reset is held
        #5;
        checkOutput("reset_state", 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held", 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle through the synchroniser release
        addVec(16'h0000, 1'b0, 32'h0, "idle0");
        addVec(16'h0000, 1'b0, 32'h0, "idle1");
        addVec(16'h0000, 1'b0, 32'h0, "idle2");
        // Basic packet 0x12345678 with TTC bits set
        addVec(16'hFC12, 1'b0, 32'h0, "pkt1_f0");
        addVec(16'hF345, 1'b0, 32'h0, "pkt1_f1");
        addVec(16'hF678, 1'b0, 32'h0, "pkt1_f2");
        addVec(16'hFABC, 1'b1, 32'h12345678, "pkt1_trailer");
        // Back-to-back 0xDEADBEEF then 0x00000001
        addVec(16'h5CDE, 1'b0, 32'h12345678, "b2b_a_f0");
        addVec(16'h3ADB, 1'b0, 32'h12345678, "b2b_a_f1");
        addVec(16'hAEEF, 1'b0, 32'h12345678, "b2b_a_f2");
        addVec(16'h0ABC, 1'b1, 32'hDEADBEEF, "b2b_a_trailer");
        addVec(16'h0C00, 1'b0, 32'hDEADBEEF, "b2b_b_f0");
        addVec(16'h0000, 1'b0, 32'hDEADBEEF, "b2b_b_f1");
        addVec(16'h0001, 1'b0, 32'hDEADBEEF, "b2b_b_f2");
        addVec(16'h0ABC, 1'b1, 32'h00000001, "b2b_b_trailer");
        // Bad trailer ABD drops the packet, following packet decodes
        addVec(16'h0C11, 1'b0, 32'h00000001, "bad_f0");
        addVec(16'h0222, 1'b0, 32'h00000001, "bad_f1");
        addVec(16'h0333, 1'b0, 32'h00000001, "bad_f2");
        addVec(16'h0ABD, 1'b0, 32'h00000001, "bad_trailer");
        addVec(16'h0C9A, 1'b0, 32'h00000001, "after_bad_f0");
        addVec(16'h0BCD, 1'b0, 32'h00000001, "after_bad_f1");
        addVec(16'h0EF0, 1'b0, 32'h00000001, "after_bad_f2");
        addVec(16'h0ABC, 1'b1, 32'h9ABCDEF0, "after_bad_trailer");
        // Idle and non-start payloads, including a stray trailer value
        addVec(16'h0000, 1'b0, 32'h9ABCDEF0, "nostart_idle");
        addVec(16'h0B12, 1'b0, 32'h9ABCDEF0, "nostart_b");
        addVec(16'h0D34, 1'b0, 32'h9ABCDEF0, "nostart_d");
        addVec(16'hF0FF, 1'b0, 32'h9ABCDEF0, "nostart_ttc");
        addVec(16'h0ABC, 1'b0, 32'h9ABCDEF0, "stray_trailer");
        // Start tag inside D1 is data
        addVec(16'h0C55, 1'b0, 32'h9ABCDEF0, "d1tag_f0");
        addVec(16'h0C00, 1'b0, 32'h9ABCDEF0, "d1tag_f1");
        addVec(16'h0123, 1'b0, 32'h9ABCDEF0, "d1tag_f2");
        addVec(16'h0ABC, 1'b1, 32'h55C00123, "d1tag_trailer");
        // Start tag inside D2 is data; non-start bad trailer returns to IDLE
        addVec(16'h0CAA, 1'b0, 32'h55C00123, "d2tag_f0");
        addVec(16'h0BBB, 1'b0, 32'h55C00123, "d2tag_f1");
        addVec(16'h0CCC, 1'b0, 32'h55C00123, "d2tag_f2");
        addVec(16'h0123, 1'b0, 32'h55C00123, "d2tag_bad_trailer");
        addVec(16'h0ABC, 1'b0, 32'h55C00123, "idle_after_drop");
        // Failed trailer carrying C12 restarts as F0
        addVec(16'h0C77, 1'b0, 32'h55C00123, "restart_f0");
        addVec(16'h0888, 1'b0, 32'h55C00123, "restart_f1");
        addVec(16'h0999, 1'b0, 32'h55C00123, "restart_f2");
        addVec(16'h0C12, 1'b0, 32'h55C00123, "restart_new_f0");
        addVec(16'h0345, 1'b0, 32'h55C00123, "restart_new_f1");
        addVec(16'h0678, 1'b0, 32'h55C00123, "restart_new_f2");
        addVec(16'h0ABC, 1'b1, 32'h12345678, "restart_trailer");
        addVec(16'h0000, 1'b0, 32'h12345678, "strobe_single");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].frame);
            checkOutput(vecs[i].name, vecs[i].exp_en, vecs[i].exp_data);
        end

        // Reset asserted while the FSM sits in D2
        applyStimulus(16'h0C11);
        applyStimulus(16'h0222);
        checkOutput("before_midreset", 1'b0, 32'h12345678);
        @(negedge clk);
        gbt_data = 16'h0333;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_immediate", 1'b0, 32'h0);
        applyStimulus(16'h0ABC);
        checkOutput("midreset_held", 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(16'h0000);
            checkOutput("post_reset_idle", 1'b0, 32'h0);
        end

        // Full packet 0xA5A5A5A5 after reset release
        applyStimulus(16'h0CA5);
        checkOutput("a5_f0", 1'b0, 32'h0);
        applyStimulus(16'h0A5A);
        checkOutput("a5_f1", 1'b0, 32'h0);
        applyStimulus(16'h05A5);
        checkOutput("a5_f2", 1'b0, 32'h0);
        applyStimulus(16'h3ABC);
        checkOutput("a5_trailer", 1'b1, 32'hA5A5A5A5);
        applyStimulus(16'h0000);
        checkOutput("a5_hold", 1'b0, 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
